// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the RV32I data memory: access-size encodings and
// the byte-lane alignment rule.
package rv32i_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    // Byte: any lane; half: even lanes; word: lane 0; reserved size never legal.
    function automatic logic lane_legal(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lane[0];
            SZ_WORD: ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32i_mem_lane.sv
// Combinational lane steering: byte enables, store-data replication across
// lanes and the alignment-legal flag for one access.
module rv32i_mem_lane
    import rv32i_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_rep_o,
    output logic        legal_o
);

    always_comb begin
        legal_o     = lane_legal(size_i, lane_i);
        byte_en_o   = 4'b0000;
        wdata_rep_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                byte_en_o   = 4'b0001 << lane_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                byte_en_o   = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                byte_en_o = 4'b1111;
            end
            default: begin
                byte_en_o = 4'b0000;
            end
        endcase
        // An illegal access must never touch storage.
        if (!legal_o) begin
            byte_en_o = 4'b0000;
        end
    end

endmodule

// File: rtl/rv32i_data_mem.sv
// RV32I data memory: byte-addressed, little-endian word array with
// registered loads, misalignment reporting and saturating access counters.
module rv32i_data_mem
    import rv32i_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      MemAddr,
    input  logic [31:0]      toMem,
    input  logic             EnWrite,
    input  logic             EnRead,
    input  logic [1:0]       addMemControl,
    output logic [31:0]      fromMem,
    output logic             rdValid,
    output logic             misalign,
    output logic             errSticky,
    output logic [CNT_W-1:0] wrCount,
    output logic [CNT_W-1:0] rdCount
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [AW-1:0]    word_idx;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_rep;
    logic             legal;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [31:0]      load_data;
    logic             wr_ok;
    logic             rd_ok;
    logic             mis;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      from_mem_q, from_mem_d;
    logic             rd_valid_q, rd_valid_d;
    logic             misalign_q, misalign_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;

    // Address bits above the array wrap silently.
    logic unused_addr;
    assign unused_addr = ^MemAddr[31:AW+2];

    assign word_idx = MemAddr[AW+1:2];
    assign rd_word  = mem_q[word_idx];
    assign rd_shift = rd_word >> {MemAddr[1:0], 3'b000};

    rv32i_mem_lane u_lane (
        .size_i      (addMemControl),
        .lane_i      (MemAddr[1:0]),
        .wdata_i     (toMem),
        .byte_en_o   (byte_en),
        .wdata_rep_o (wdata_rep),
        .legal_o     (legal)
    );

    always_comb begin
        wr_ok = EnWrite && legal && !reset;
        // A simultaneous read and write keeps the store but drops the load.
        rd_ok = EnRead && !EnWrite && legal;
        mis   = (EnRead && EnWrite) || ((EnRead || EnWrite) && !legal);

        case (addMemControl)
            SZ_BYTE: load_data = {24'b0, rd_shift[7:0]};
            SZ_HALF: load_data = {16'b0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase

        from_mem_d   = rd_ok ? load_data : from_mem_q;
        rd_valid_d   = rd_ok;
        misalign_d   = mis;
        err_sticky_d = err_sticky_q | mis;
        wr_count_d   = wr_count_q;
        rd_count_d   = rd_count_q;
        if (wr_ok && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
        if (rd_ok && (rd_count_q != '1)) begin
            rd_count_d = rd_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            from_mem_q   <= '0;
            rd_valid_q   <= 1'b0;
            misalign_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            wr_count_q   <= '0;
            rd_count_q   <= '0;
        end else begin
            from_mem_q   <= from_mem_d;
            rd_valid_q   <= rd_valid_d;
            misalign_q   <= misalign_d;
            err_sticky_q <= err_sticky_d;
            wr_count_q   <= wr_count_d;
            rd_count_q   <= rd_count_d;
        end
    end

    // Storage deliberately sits outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_ok && byte_en[b]) begin
                mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign fromMem   = from_mem_q;
    assign rdValid   = rd_valid_q;
    assign misalign  = misalign_q;
    assign errSticky = err_sticky_q;
    assign wrCount   = wr_count_q;
    assign rdCount   = rd_count_q;

endmodule

// File: tb/tb_rv32i_data_mem.sv
// Scoreboard bench for rv32i_data_mem: directed accesses push expected load
// data and misalign pulses; a negedge monitor checks them cycle by cycle.
module tb_rv32i_data_mem;

    logic        clk;
    logic        reset;
    logic [31:0] MemAddr;
    logic [31:0] toMem;
    logic        EnWrite;
    logic        EnRead;
    logic [1:0]  addMemControl;

    logic [31:0] fromMem;
    logic        rdValid;
    logic        misalign;
    logic        errSticky;
    logic [15:0] wrCount;
    logic [15:0] rdCount;

    logic [31:0] sm_fromMem;
    logic        sm_rdValid;
    logic        sm_misalign;
    logic        sm_errSticky;
    logic [3:0]  sm_wrCount;
    logic [3:0]  sm_rdCount;

    rv32i_data_mem #(.DEPTH_WORDS(256), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .MemAddr       (MemAddr),
        .toMem         (toMem),
        .EnWrite       (EnWrite),
        .EnRead        (EnRead),
        .addMemControl (addMemControl),
        .fromMem       (fromMem),
        .rdValid       (rdValid),
        .misalign      (misalign),
        .errSticky     (errSticky),
        .wrCount       (wrCount),
        .rdCount       (rdCount)
    );

    rv32i_data_mem #(.DEPTH_WORDS(256), .CNT_W(4)) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .MemAddr       (MemAddr),
        .toMem         (toMem),
        .EnWrite       (EnWrite),
        .EnRead        (EnRead),
        .addMemControl (addMemControl),
        .fromMem       (sm_fromMem),
        .rdValid       (sm_rdValid),
        .misalign      (sm_misalign),
        .errSticky     (sm_errSticky),
        .wrCount       (sm_wrCount),
        .rdCount       (sm_rdCount)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      mis_q[$];
    int      cyc;
    int      n_checks;
    int      n_pass;
    int      exp_wr;
    int      exp_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_legal(input logic [1:0] sz, input logic [31:0] addr);
        if (sz == 2'b00) return 1'b1;
        if (sz == 2'b01) return addr[0] == 1'b0;
        if (sz == 2'b10) return addr[1:0] == 2'b00;
        return 1'b0;
    endfunction

    // Issue one request on the next rising edge and record what it must produce.
    task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp);
        logic    ok;
        rd_exp_t e;
        ok = model_legal(sz, addr);
        if ((rd && wr) || ((rd || wr) && !ok)) mis_q.push_back(cyc + 1);
        if (rd && !wr && ok) begin
            e.data = exp;
            e.cyc  = cyc + 1;
            rd_q.push_back(e);
            exp_rd++;
        end
        if (wr && ok) exp_wr++;
        EnRead        = rd;
        EnWrite       = wr;
        addMemControl = sz;
        MemAddr       = addr;
        toMem         = data;
        @(posedge clk);
        #1;
        EnRead  = 1'b0;
        EnWrite = 1'b0;
    endtask

    always @(negedge clk) begin
        logic exp_v;
        logic exp_m;
        rd_exp_t e;
        exp_v = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
        check("rdValid", {31'b0, rdValid}, {31'b0, exp_v});
        if (exp_v) begin
            e = rd_q.pop_front();
            check("fromMem", fromMem, e.data);
        end
        exp_m = (mis_q.size() > 0) && (mis_q[0] == cyc);
        check("misalign", {31'b0, misalign}, {31'b0, exp_m});
        if (exp_m) void'(mis_q.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        exp_wr        = 0;
        exp_rd        = 0;
        reset         = 1'b1;
        EnRead        = 1'b0;
        EnWrite       = 1'b0;
        addMemControl = 2'b00;
        MemAddr       = 32'h0;
        toMem         = 32'h0;

        #2;
        check("rst_fromMem", fromMem, 32'h0);
        check("rst_errSticky", {31'b0, errSticky}, 32'h0);
        check("rst_wrCount", {16'b0, wrCount}, 32'h0);
        check("rst_rdCount", {16'b0, rdCount}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Store, then loads back-to-back including read-after-write on the next edge.
        op(0, 1, 2'b10, 32'h10, 32'h12345678, 32'h0);
        op(1, 0, 2'b10, 32'h10, 32'h0, 32'h12345678);
        op(0, 1, 2'b00, 32'h11, 32'hFFFFFFAB, 32'h0);
        op(1, 0, 2'b10, 32'h10, 32'h0, 32'h1234AB78);
        op(1, 0, 2'b00, 32'h11, 32'h0, 32'h000000AB);
        op(1, 0, 2'b01, 32'h12, 32'h0, 32'h00001234);
        @(negedge clk);
        check("hold_fromMem", fromMem, 32'h00001234);
        check("errSticky_clean", {31'b0, errSticky}, 32'h0);

        // Rejected accesses.
        op(1, 0, 2'b10, 32'h12, 32'h0, 32'h0);
        op(0, 1, 2'b01, 32'h13, 32'hFFFF5555, 32'h0);
        op(1, 0, 2'b11, 32'h10, 32'h0, 32'h0);
        @(negedge clk);
        check("errSticky_set", {31'b0, errSticky}, 32'h1);
        check("hold_after_mis", fromMem, 32'h00001234);
        op(1, 0, 2'b10, 32'h10, 32'h0, 32'h1234AB78);

        // Simultaneous read+write: store wins, load dropped.
        op(1, 1, 2'b10, 32'h20, 32'hDEADBEEF, 32'h0);
        op(1, 0, 2'b10, 32'h20, 32'h0, 32'hDEADBEEF);

        // Aliasing above the array and partial stores.
        op(0, 1, 2'b10, 32'h400, 32'hCAFEF00D, 32'h0);
        op(1, 0, 2'b10, 32'h0, 32'h0, 32'hCAFEF00D);
        op(1, 0, 2'b10, 32'h410, 32'h0, 32'h1234AB78);
        op(0, 1, 2'b00, 32'h2, 32'hFFFFFF5A, 32'h0);
        op(1, 0, 2'b00, 32'h2, 32'h0, 32'h0000005A);
        op(1, 0, 2'b10, 32'h0, 32'h0, 32'hCA5AF00D);
        op(0, 1, 2'b01, 32'h22, 32'h99991111, 32'h0);
        op(1, 0, 2'b01, 32'h20, 32'h0, 32'h0000BEEF);
        op(1, 0, 2'b10, 32'h20, 32'h0, 32'h1111BEEF);
        @(negedge clk);
        check("wrCount", {16'b0, wrCount}, 32'(exp_wr));
        check("rdCount", {16'b0, rdCount}, 32'(exp_rd));
        check("sat_rdCount_pre", {28'b0, sm_rdCount}, (exp_rd > 15) ? 32'd15 : 32'(exp_rd));

        // Reset while a load is in flight; writes during reset must be ignored.
        @(posedge clk);
        #1;
        EnRead        = 1'b1;
        addMemControl = 2'b10;
        MemAddr       = 32'h10;
        @(posedge clk);
        #2;
        reset  = 1'b1;
        EnRead = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        #1;
        check("midrst_rdValid", {31'b0, rdValid}, 32'h0);
        check("midrst_fromMem", fromMem, 32'h0);
        check("midrst_errSticky", {31'b0, errSticky}, 32'h0);
        check("midrst_rdCount", {16'b0, rdCount}, 32'h0);
        check("midrst_wrCount", {16'b0, wrCount}, 32'h0);
        EnWrite = 1'b1;
        toMem   = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #1;
        EnWrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("postrst_wrCount", {16'b0, wrCount}, 32'h0);
        op(1, 0, 2'b10, 32'h10, 32'h0, 32'h1234AB78);

        // Saturation of the narrow counter.
        for (int i = 0; i < 20; i++) begin
            op(1, 0, 2'b10, 32'h10, 32'h0, 32'h1234AB78);
        end
        @(negedge clk);
        check("rdCount_after_sat", {16'b0, rdCount}, 32'(exp_rd));
        check("sat_rdCount", {28'b0, sm_rdCount}, 32'd15);
        check("sat_wrCount", {28'b0, sm_wrCount}, 32'd0);

        repeat (3) @(negedge clk);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("mis_queue_drained", 32'(mis_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
